// File: rtl/portao_pkg.sv
// Shared constants for the gate controller: debounce defaults and the
// gate-control FSM state encoding used by the system-level bench.
package portao_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned CNT_W_DEF           = 5;

    typedef enum logic [1:0] {
        FECHADO  = 2'b00,
        FECHANDO = 2'b01,
        ABRINDO  = 2'b10,
        ABERTO   = 2'b11
    } estado_portao_t;

    typedef struct packed {
        logic botao;
        logic aberto;
        logic fechado;
        logic sensor;
    } canais_t;

endpackage

// File: rtl/debounce_canal.sv
// One input channel: 2-flop synchronizer followed by a saturating debounce
// counter; FAST_ASSERT lets a rising level bypass the debounce.
module debounce_canal
    import portao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF,
    parameter bit          FAST_ASSERT     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic d
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_d   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            if (r_s2 == r_d) begin
                r_cnt <= '0;
            end else if (FAST_ASSERT && r_s2) begin
                // Obstacle appearing is acted on at once; only its release is filtered.
                r_d   <= 1'b1;
                r_cnt <= '0;
            end else if (r_cnt == CNT_LIM) begin
                r_d   <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign d = r_d;

endmodule

// File: rtl/condicionador_entradas_portao.sv
// Conditions the raw button, limit switches and obstacle sensor for the
// gate FSM: debounce, button edge pulse and limit-switch fault masking.
module condicionador_entradas_portao
    import portao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_raw,
    input  logic fim_curso_aberto_raw,
    input  logic fim_curso_fechado_raw,
    input  logic sensor_raw,
    output logic controle,
    output logic trilhoAberto,
    output logic trilhoFechado,
    output logic sensor,
    output logic erro_trilho
);

    canais_t w_d;
    logic    r_botao_q;

    debounce_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .FAST_ASSERT    (1'b0)
    ) u_botao (
        .clock(clock),
        .reset(reset),
        .raw  (botao_raw),
        .d    (w_d.botao)
    );

    debounce_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .FAST_ASSERT    (1'b0)
    ) u_aberto (
        .clock(clock),
        .reset(reset),
        .raw  (fim_curso_aberto_raw),
        .d    (w_d.aberto)
    );

    debounce_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .FAST_ASSERT    (1'b0)
    ) u_fechado (
        .clock(clock),
        .reset(reset),
        .raw  (fim_curso_fechado_raw),
        .d    (w_d.fechado)
    );

    debounce_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .FAST_ASSERT    (1'b1)
    ) u_sensor (
        .clock(clock),
        .reset(reset),
        .raw  (sensor_raw),
        .d    (w_d.sensor)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_botao_q <= 1'b0;
        end else begin
            r_botao_q <= w_d.botao;
        end
    end

    // Both rails active at once is physically impossible: report it and hide both.
    always_comb begin
        controle      = w_d.botao & ~r_botao_q;
        erro_trilho   = w_d.aberto & w_d.fechado;
        trilhoAberto  = w_d.aberto & ~w_d.fechado;
        trilhoFechado = w_d.fechado & ~w_d.aberto;
        sensor        = w_d.sensor;
    end

endmodule

// File: tb/tb_condicionador_entradas_portao.sv
// Directed bench for the input conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// "Edge e" is the e-th posedge at which a newly driven raw level is sampled.
module tb_condicionador_entradas_portao;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic botao_raw = 1'b0;
    logic fim_curso_aberto_raw = 1'b0;
    logic fim_curso_fechado_raw = 1'b0;
    logic sensor_raw = 1'b0;
    logic controle;
    logic trilhoAberto;
    logic trilhoFechado;
    logic sensor;
    logic erro_trilho;

    int checks = 0;
    int errors = 0;

    condicionador_entradas_portao #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .botao_raw            (botao_raw),
        .fim_curso_aberto_raw (fim_curso_aberto_raw),
        .fim_curso_fechado_raw(fim_curso_fechado_raw),
        .sensor_raw           (sensor_raw),
        .controle             (controle),
        .trilhoAberto         (trilhoAberto),
        .trilhoFechado        (trilhoFechado),
        .sensor               (sensor),
        .erro_trilho          (erro_trilho)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        botao_raw             = 1'b0;
        fim_curso_aberto_raw  = 1'b0;
        fim_curso_fechado_raw = 1'b0;
        sensor_raw            = 1'b0;
        reset                 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        botao_raw             = 1'b1;
        fim_curso_aberto_raw  = 1'b1;
        fim_curso_fechado_raw = 1'b1;
        sensor_raw            = 1'b1;
        reset                 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {controle, trilhoAberto, trilhoFechado, sensor, erro_trilho};
            checks++;
            if (outs !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: outputs=%b required=00000", i, outs);
            end
        end
        reset = 1'b0;
        for (int e = 0; e < 9; e++) begin
            tick();
            checks++;
            if (controle !== (e == 5)) begin
                errors++;
                $display("FAIL reset_rel_controle edge%0d: got=%b required=%b", e, controle, (e == 5));
            end
            checks++;
            if (erro_trilho !== (e >= 5)) begin
                errors++;
                $display("FAIL reset_rel_erro edge%0d: got=%b required=%b", e, erro_trilho, (e >= 5));
            end
            checks++;
            if (sensor !== (e >= 2)) begin
                errors++;
                $display("FAIL reset_rel_sensor edge%0d: got=%b required=%b", e, sensor, (e >= 2));
            end
            checks++;
            if ({trilhoAberto, trilhoFechado} !== 2'b00) begin
                errors++;
                $display("FAIL reset_rel_trilhos edge%0d: got=%b%b required=00", e, trilhoAberto, trilhoFechado);
            end
        end
    endtask

    task automatic test_botao_hold();
        do_reset();
        botao_raw = 1'b1;
        for (int e = 0; e < 30; e++) begin
            if (e == 20) botao_raw = 1'b0;
            tick();
            checks++;
            if (controle !== (e == 5)) begin
                errors++;
                $display("FAIL botao_hold edge%0d: controle=%b required=%b", e, controle, (e == 5));
            end
        end
    endtask

    task automatic test_botao_curto();
        do_reset();
        botao_raw = 1'b1;
        for (int e = 0; e < 15; e++) begin
            if (e == 3) botao_raw = 1'b0;
            tick();
            checks++;
            if (controle !== 1'b0) begin
                errors++;
                $display("FAIL botao_curto edge%0d: controle=%b required=0", e, controle);
            end
        end
    endtask

    task automatic test_botao_limite();
        do_reset();
        botao_raw = 1'b1;
        for (int e = 0; e < 15; e++) begin
            if (e == 4) botao_raw = 1'b0;
            tick();
            checks++;
            if (controle !== (e == 5)) begin
                errors++;
                $display("FAIL botao_limite edge%0d: controle=%b required=%b", e, controle, (e == 5));
            end
        end
    endtask

    task automatic test_sensor();
        do_reset();
        sensor_raw = 1'b1;
        for (int e = 0; e < 20; e++) begin
            if (e == 10) sensor_raw = 1'b0;
            tick();
            checks++;
            if (sensor !== (e >= 2 && e < 15)) begin
                errors++;
                $display("FAIL sensor_assert_release edge%0d: sensor=%b required=%b", e, sensor, (e >= 2 && e < 15));
            end
        end
        sensor_raw = 1'b1;
        tick();
        tick();
        tick();
        for (int e = 0; e < 12; e++) begin
            if (e == 0) sensor_raw = 1'b0;
            if (e == 1) sensor_raw = 1'b1;
            tick();
            checks++;
            if (sensor !== 1'b1) begin
                errors++;
                $display("FAIL sensor_glitch edge%0d: sensor=%b required=1", e, sensor);
            end
        end
    endtask

    task automatic test_limites();
        do_reset();
        fim_curso_aberto_raw  = 1'b1;
        fim_curso_fechado_raw = 1'b1;
        for (int e = 0; e < 20; e++) begin
            if (e == 10) fim_curso_fechado_raw = 1'b0;
            tick();
            checks++;
            if (erro_trilho !== (e >= 5 && e < 15)) begin
                errors++;
                $display("FAIL limite_erro edge%0d: erro_trilho=%b required=%b", e, erro_trilho, (e >= 5 && e < 15));
            end
            checks++;
            if (trilhoAberto !== (e >= 15)) begin
                errors++;
                $display("FAIL limite_aberto edge%0d: trilhoAberto=%b required=%b", e, trilhoAberto, (e >= 15));
            end
            checks++;
            if (trilhoFechado !== 1'b0) begin
                errors++;
                $display("FAIL limite_fechado edge%0d: trilhoFechado=%b required=0", e, trilhoFechado);
            end
        end
    endtask

    task automatic test_reset_meio();
        do_reset();
        botao_raw = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (controle !== 1'b0) begin
                errors++;
                $display("FAIL reset_meio_pre edge%0d: controle=%b required=0", e, controle);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (controle !== 1'b0) begin
            errors++;
            $display("FAIL reset_meio_in: controle=%b required=0", controle);
        end
        reset = 1'b0;
        for (int e = 4; e < 14; e++) begin
            tick();
            checks++;
            if (controle !== (e == 9)) begin
                errors++;
                $display("FAIL reset_meio_post edge%0d: controle=%b required=%b", e, controle, (e == 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        botao_raw            = 1'b1;
        sensor_raw           = 1'b1;
        fim_curso_aberto_raw = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (controle !== (e == 5)) begin
                errors++;
                $display("FAIL paralelo_controle edge%0d: got=%b required=%b", e, controle, (e == 5));
            end
            checks++;
            if (sensor !== (e >= 2)) begin
                errors++;
                $display("FAIL paralelo_sensor edge%0d: got=%b required=%b", e, sensor, (e >= 2));
            end
            checks++;
            if ({trilhoAberto, trilhoFechado, erro_trilho} !== {(e >= 5), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL paralelo_limites edge%0d: got=%b%b%b required=%b00", e, trilhoAberto, trilhoFechado, erro_trilho, (e >= 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_botao_hold();
        test_botao_curto();
        test_botao_limite();
        test_sensor();
        test_limites();
        test_reset_meio();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
